// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Build option MIPS_MC_PERF_CNT_EN (used by mips_mc_control) adds performance counters.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_FAULT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] ALU_FUNCT = 6'b000000;
    localparam logic [5:0] ALU_ADD   = 6'b100011;
    localparam logic [5:0] ALU_SUB   = 6'b000100;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] ASB_B       = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:                     return S_MEM_ADDR;
            OP_R:                             return S_R_EXEC;
            OP_BEQ, OP_BNE:                   return S_BRANCH;
            OP_J, OP_JAL:                     return S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_I_EXEC;
            default:                          return S_FAULT;
        endcase
    endfunction

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_mc_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave).
// Handshake: the controller holds mem_read/mem_write until a cycle with mem_ready=1 completes the access.
interface mips_mc_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_op;
    logic       instr_done;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, wb_src, alu_src_a, alu_src_b, alu_op, instr_done, fault, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, wb_src, alu_src_a, alu_src_b, alu_op, instr_done, fault, state
    );
endinterface

// File: rtl/mips_mc_wait_timer.sv
// Saturating wait-state counter; expired flags the cycle in which the TIMEOUT-th wait occurs.
// TIMEOUT=0 turns the timeout off entirely.
module mips_mc_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic wait_req,
    output logic expired
);
    localparam logic [TO_W-1:0] LIMIT = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
    localparam logic [TO_W-1:0] MAX   = '1;
    localparam logic [TO_W-1:0] ONE   = TO_W'(1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (wait_req && (cnt != MAX))
            cnt <= cnt + ONE;
    end

    // A ready in the same cycle never counts as a wait, so completion wins over timeout.
    assign expired = (TIMEOUT > 0) && wait_req && (cnt >= LIMIT);
endmodule

// File: rtl/mips_mc_control.sv
// Moore control FSM for the multi-cycle MIPS core with a shared ALU and unified memory port.
// Define MIPS_MC_PERF_CNT_EN to add cycle_cnt/instr_cnt performance counters.
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
`ifdef MIPS_MC_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic      clk,
    input  logic      rst,
    mips_mc_if.master bus
`ifdef MIPS_MC_PERF_CNT_EN
    , output logic [CNT_W-1:0] cycle_cnt
    , output logic [CNT_W-1:0] instr_cnt
`endif
);
    state_t state_q, state_d;
    logic   wait_req, clr, expired;

    assign wait_req = is_mem_state(state_q) && !bus.mem_ready;
    assign clr      = (state_d != state_q);

    mips_mc_wait_timer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wait_req (wait_req),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign bus.state = state_q;
    assign bus.fault = (state_q == S_FAULT);

    always_comb begin
        state_d        = state_q;
        bus.pc_en      = 1'b0;
        bus.pc_src     = PC_SRC_ALU;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = REG_DST_RT;
        bus.wb_src     = WB_ALUOUT;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = ASB_B;
        bus.alu_op     = ALU_FUNCT;
        bus.instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = ASB_FOUR;
                bus.alu_op    = ALU_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
                else if (expired)  state_d = S_FAULT;
            end
            S_DECODE: begin
                bus.alu_src_b = ASB_IMM_SH2;
                bus.alu_op    = ALU_ADD;
                state_d       = decode_next(bus.opcode);
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ASB_IMM;
                bus.alu_op    = ALU_ADD;
                state_d       = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
                else if (expired)  state_d = S_FAULT;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.wb_src     = WB_MDR;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                bus.mem_write  = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
                else if (expired)  state_d = S_FAULT;
            end
            S_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = REG_DST_RD;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ASB_IMM;
                bus.alu_op    = bus.opcode;
                state_d       = S_I_WB;
            end
            S_I_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                // ALUOut already holds the branch target computed in DECODE.
                bus.alu_src_a  = 1'b1;
                bus.alu_op     = ALU_SUB;
                bus.pc_src     = PC_SRC_ALUOUT;
                bus.pc_en      = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_src     = PC_SRC_JUMP;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
                if (bus.opcode == OP_JAL) begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = REG_DST_RA;
                    bus.wb_src    = WB_PC;
                end
                state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

`ifdef MIPS_MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_q != S_FAULT) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (bus.instr_done)     instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: instruction-level sequence model feeding an expected queue,
// a per-cycle compare process, and literal checks on the captured output trace.
module tb_mips_mc_control;
  import mips_mc_pkg::*;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       alu_a;
    logic [1:0] alu_b;
    logic [5:0] alu_op;
    logic       done;
    logic       fault;
  } rec_t;

  localparam int RW = $bits(rec_t);

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [RW-1:0] exp_q[$];
  rec_t          act_q[$];

  mips_mc_if bus();

`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
  mips_mc_control #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));
`else
  mips_mc_control #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // compare process: every cycle with a pending expectation is checked
  always @(negedge clk) begin : cmp
    rec_t a;
    logic [RW-1:0] e;
    a.st = bus.state;         a.pc_en = bus.pc_en;         a.pc_src = bus.pc_src;
    a.iord = bus.iord;        a.mem_read = bus.mem_read;   a.mem_write = bus.mem_write;
    a.ir_write = bus.ir_write; a.reg_write = bus.reg_write; a.reg_dst = bus.reg_dst;
    a.wb_src = bus.wb_src;    a.alu_a = bus.alu_src_a;     a.alu_b = bus.alu_src_b;
    a.alu_op = bus.alu_op;    a.done = bus.instr_done;     a.fault = bus.fault;
    act_q.push_back(a);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got state=%0d outputs=%h, required state=%0d outputs=%h",
                 $time, a.st, a, e[RW-1 -: 4], e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic rec_t at(input int i);
    if (i < act_q.size()) return act_q[i];
    return '1;
  endfunction

  function automatic int count_done();
    int n = 0;
    foreach (act_q[i]) if (act_q[i].done) n++;
    return n;
  endfunction

  // expected-record builders, one per step of an instruction
  function automatic rec_t mk(input state_t s);
    rec_t r;
    r = '0;
    r.st = s;
    r.fault = (s == S_FAULT);
    return r;
  endfunction

  function automatic rec_t rec_fetch(input logic rdy);
    rec_t r;
    r = mk(S_FETCH);
    r.mem_read = 1'b1; r.alu_b = 2'b01; r.alu_op = 6'b100011;
    r.ir_write = rdy;  r.pc_en = rdy;
    return r;
  endfunction

  function automatic rec_t rec_decode();
    rec_t r;
    r = mk(S_DECODE);
    r.alu_b = 2'b11; r.alu_op = 6'b100011;
    return r;
  endfunction

  // driver: apply one cycle of stimulus and queue what that cycle must show
  task automatic cyc(input logic rdy, input rec_t r);
    bus.mem_ready = rdy;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // memory access that waits 'waits' cycles; TIMEOUT consecutive waits end in FAULT
  task automatic wait_phase(input rec_t busy, input rec_t fin, input int waits, output bit faulted);
    int n;
    faulted = (waits >= TIMEOUT);
    n = faulted ? TIMEOUT : waits;
    for (int i = 0; i < n; i++) cyc(1'b0, busy);
    if (faulted) repeat (3) cyc(1'b1, mk(S_FAULT));
    else cyc(1'b1, fin);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    rec_t r, busy, fin;
    bit f;
    bus.opcode = op;
    bus.zero = z;
    wait_phase(rec_fetch(1'b0), rec_fetch(1'b1), fw, f);
    if (f) return;
    cyc(1'b1, rec_decode());
    case (op)
      OP_LW, OP_SW: begin
        r = mk(S_MEM_ADDR); r.alu_a = 1'b1; r.alu_b = 2'b10; r.alu_op = 6'b100011;
        cyc(1'b1, r);
        busy = mk(op == OP_LW ? S_MEM_READ : S_MEM_WRITE);
        busy.iord = 1'b1;
        if (op == OP_LW) busy.mem_read = 1'b1; else busy.mem_write = 1'b1;
        fin = busy;
        if (op == OP_SW) fin.done = 1'b1;
        wait_phase(busy, fin, mw, f);
        if (f) return;
        if (op == OP_LW) begin
          r = mk(S_MEM_WB); r.reg_write = 1'b1; r.wb_src = 2'b01; r.done = 1'b1;
          cyc(1'b1, r);
        end
      end
      OP_R: begin
        r = mk(S_R_EXEC); r.alu_a = 1'b1;
        cyc(1'b1, r);
        r = mk(S_R_WB); r.reg_write = 1'b1; r.reg_dst = 2'b01; r.done = 1'b1;
        cyc(1'b1, r);
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        r = mk(S_I_EXEC); r.alu_a = 1'b1; r.alu_b = 2'b10; r.alu_op = op;
        cyc(1'b1, r);
        r = mk(S_I_WB); r.reg_write = 1'b1; r.done = 1'b1;
        cyc(1'b1, r);
      end
      OP_BEQ, OP_BNE: begin
        r = mk(S_BRANCH); r.alu_a = 1'b1; r.alu_op = 6'b000100; r.pc_src = 2'b01; r.done = 1'b1;
        r.pc_en = (op == OP_BEQ) ? z : !z;
        cyc(1'b1, r);
      end
      OP_J, OP_JAL: begin
        r = mk(S_JUMP); r.pc_src = 2'b10; r.pc_en = 1'b1; r.done = 1'b1;
        if (op == OP_JAL) begin r.reg_write = 1'b1; r.reg_dst = 2'b10; r.wb_src = 2'b10; end
        cyc(1'b1, r);
      end
      default: repeat (3) cyc(1'b1, mk(S_FAULT));
    endcase
  endtask

  typedef struct { logic [5:0] op; logic z; int fw; int mw; } vec_t;
  vec_t mix[10];

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'b0;
    bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // add immediately after reset
    act_q.delete();
    run_instr(OP_R, 1'b0, 0, 0);
    chk("reset_state", 32'(at(0).st), 32'd0);
    chk("reset_fault", 32'(at(0).fault), 32'd0);
    chk("first_pc_en", 32'(at(0).pc_en), 32'd1);
    chk("first_ir_write", 32'(at(0).ir_write), 32'd1);
    chk("decode_after_fetch", 32'(at(1).st), 32'd1);
    chk("r_wb_reg_write", 32'(at(3).reg_write), 32'd1);
    chk("r_wb_reg_dst", 32'(at(3).reg_dst), 32'd1);
    chk("add_done_once", 32'(count_done()), 32'd1);
    chk("add_cycles", 32'(act_q.size()), 32'd4);

    // lw with 3 wait states in MEM_READ
    act_q.delete();
    run_instr(OP_LW, 1'b0, 0, 3);
    chk("lw_cycles", 32'(act_q.size()), 32'd8);
    for (int i = 3; i <= 6; i++) chk("lw_mem_read_held", 32'(at(i).st), 32'd3);
    chk("lw_mem_wb_state", 32'(at(7).st), 32'd4);
    chk("lw_mem_wb_src", 32'(at(7).wb_src), 32'd1);

    // beq then bne with zero=1
    act_q.delete();
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BNE, 1'b1, 0, 0);
    chk("beq_pc_en", 32'(at(2).pc_en), 32'd1);
    chk("beq_pc_src", 32'(at(2).pc_src), 32'd1);
    chk("bne_pc_en", 32'(at(5).pc_en), 32'd0);
    chk("bne_pc_src", 32'(at(5).pc_src), 32'd1);

    // jal
    act_q.delete();
    run_instr(OP_JAL, 1'b0, 0, 0);
    chk("jal_state", 32'(at(2).st), 32'd11);
    chk("jal_pc_en", 32'(at(2).pc_en), 32'd1);
    chk("jal_reg_write", 32'(at(2).reg_write), 32'd1);
    chk("jal_reg_dst", 32'(at(2).reg_dst), 32'd2);
    chk("jal_wb_src", 32'(at(2).wb_src), 32'd2);

    // mixed instructions with wait states
    mix[0] = '{OP_SW,   1'b0, 1, 2};
    mix[1] = '{OP_ADDI, 1'b0, 2, 0};
    mix[2] = '{OP_ANDI, 1'b0, 0, 0};
    mix[3] = '{OP_ORI,  1'b1, 0, 0};
    mix[4] = '{OP_SLTI, 1'b0, 3, 0};
    mix[5] = '{OP_J,    1'b0, 0, 0};
    mix[6] = '{OP_BEQ,  1'b0, 0, 0};
    mix[7] = '{OP_BNE,  1'b0, 1, 0};
    mix[8] = '{OP_SW,   1'b0, 0, 0};
    mix[9] = '{OP_LW,   1'b0, 0, 15};
    foreach (mix[i]) run_instr(mix[i].op, mix[i].z, mix[i].fw, mix[i].mw);

    // one wait short of the timeout still completes
    act_q.delete();
    run_instr(OP_LW, 1'b0, 15, 0);
    chk("fetch_15_waits_cycles", 32'(act_q.size()), 32'd20);
    chk("fetch_15_waits_no_fault", 32'(at(19).fault), 32'd0);

    // illegal opcode
    act_q.delete();
    run_instr(6'b111111, 1'b0, 0, 0);
    chk("illegal_decode", 32'(at(1).st), 32'd1);
    chk("illegal_fault_state", 32'(at(2).st), 32'd12);
    chk("illegal_fault_flag", 32'(at(4).fault), 32'd1);
    do_reset();

    // fetch timeout after reset
    act_q.delete();
    run_instr(OP_R, 1'b0, 16, 0);
    chk("timeout_still_fetch_c16", 32'(at(15).st), 32'd0);
    chk("timeout_fault_c17", 32'(at(16).fault), 32'd1);
    chk("timeout_fault_state", 32'(at(16).st), 32'd12);
    do_reset();

    // store timeout, then recovery
    run_instr(OP_SW, 1'b0, 0, 20);
    do_reset();
    act_q.delete();
    run_instr(OP_ADDI, 1'b0, 0, 0);
    chk("recover_fault_cleared", 32'(at(0).fault), 32'd0);
    chk("recover_i_wb", 32'(at(3).st), 32'd9);

    // reset in the middle of an instruction
    bus.opcode = OP_LW;
    cyc(1'b1, rec_fetch(1'b1));
    cyc(1'b1, rec_decode());
    do_reset();
    act_q.delete();
    run_instr(OP_R, 1'b0, 0, 0);
    chk("midreset_fetch", 32'(at(0).st), 32'd0);
    chk("midreset_done_once", 32'(count_done()), 32'd1);

    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
Multi-cycle successor to the single-cycle CONTROL decoder. It is a Moore FSM that sequences each MIPS instruction over 3-5 states, sharing one ALU and one unified memory port. Every memory access waits on a ready handshake, so the core tolerates wait-state memories. It sits beside the datapath registers (IR, MDR, A, B, ALUOut) and drives all of their enables and mux selects.

Parameters:
TIMEOUT, 16, max cycles waiting on mem_ready before FAULT; 0 disables timeout
TO_W, 5, width of wait counter; must satisfy 2^TO_W > TIMEOUT
CNT_W, 32, width of performance counters (PERF_CNT_EN only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
pc_en  out  1  PC register load enable
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
iord  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
reg_write  out  1  register bank write enable
reg_dst  out  2  00 rt, 01 rd, 10 $31
wb_src  out  2  00 ALUOut, 01 MDR, 10 PC (link)
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  6  opcode-style code to ALU_CONTROL: 000000 funct, 100011 add, 000100 sub, otherwise I-type opcode passthrough
instr_done  out  1  one-cycle pulse on the final state of each instruction
fault  out  1  sticky; illegal opcode or memory timeout
state  out  4  current state encoding, for debug

Behaviour:
- Reset (rst=1 at posedge): state=FETCH, wait counter=0, fault=0. All outputs are decoded from the state and are therefore FETCH values after reset. rst overrides everything, including mid-instruction and FAULT.
- FETCH: mem_read=1, iord=0, ir_write=mem_ready, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00, pc_en=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (precomputes branch target into ALUOut). Next state by opcode:
  - lw/sw → MEM_ADDR
  - R-type → R_EXEC
  - beq/bne → BRANCH
  - j/jal → JUMP
  - addi/andi/ori/slti → I_EXEC
  - any other opcode → FAULT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Stay until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, wb_src=01, instr_done=1, then FETCH.
- MEM_WRITE: mem_write=1, iord=1. Stay until mem_ready; on mem_ready, instr_done=1 and go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=000000, then R_WB.
- R_WB: reg_write=1, reg_dst=01, wb_src=00, instr_done=1, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=opcode, then I_WB.
- I_WB: reg_write=1, reg_dst=00, wb_src=00, instr_done=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01. pc_en = zero for beq, ~zero for bne. instr_done=1, then FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. jal additionally sets reg_write=1, reg_dst=10, wb_src=10 (PC already holds PC+4). Then FETCH.
- Wait counter:
  - Cleared on entry to any memory state; increments each cycle mem_ready=0 in FETCH/MEM_READ/MEM_WRITE.
  - With TIMEOUT>0, reaching TIMEOUT with mem_ready still 0 → FAULT on the next edge.
  - mem_ready=1 in the same cycle the count reaches TIMEOUT counts as success; the access completes normally.
  - The counter saturates and never wraps.
- FAULT: all enables 0, fault=1. Only rst leaves it.
- mem_read and mem_write are never asserted together. At most one of pc_en, reg_write, mem_write is asserted per state, except JUMP for jal (pc_en and reg_write together).

Optional Feature:
MIPS_MC_PERF_CNT_EN:
- Defined: adds outputs cycle_cnt[CNT_W] (increments every non-reset cycle outside FAULT) and instr_cnt[CNT_W] (increments on instr_done). Both clear on rst and wrap modulo 2^CNT_W.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package mips_mc_pkg: state enum (13 states, 4-bit), opcode constants (R, LW, SW, BEQ, BNE, J, JAL, ADDI, ANDI, ORI, SLTI), alu_op codes, and pc_src/reg_dst/wb_src/alu_src_b encodings.
- Sub-module mips_mc_wait_timer: wait counter plus timeout compare; inputs clr, wait, TIMEOUT; output expired.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 → state=FETCH, fault=0, pc_en=1 and ir_write=1 in first cycle, DECODE next.
- add (opcode 000000), mem_ready=1 → states FETCH, DECODE, R_EXEC, R_WB; reg_write=1 and reg_dst=01 in R_WB; instr_done exactly once.
- lw with mem_ready low 3 cycles in MEM_READ → MEM_READ held 4 cycles, then MEM_WB with wb_src=01; 5+3 cycles total.
- beq with zero=1, then bne with zero=1 → pc_en=1 in first BRANCH, pc_en=0 in second, pc_src=01 both.
- jal (000011) → JUMP with pc_en=1, reg_write=1, reg_dst=10, wb_src=10.
- Opcode 111111 → FAULT after DECODE; then mem_ready=0 for 16 cycles in FETCH (after rst) → fault=1 at cycle 17. rst clears fault in both cases.
